// File: rtl/display_source_arbiter.sv
// rtl/display_source_arbiter.sv - round-robin owner of the six-digit hex display with minimum dwell
// Optional: define DISP_ARB_SRCID_EN to show the owner index on hex5 instead of data nibble 5.
module display_source_arbiter #(
    parameter int NREQ    = 3,
    parameter int DWELL   = 50000000,
    parameter int DWELL_W = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [24*NREQ-1:0]   data,
    output logic [NREQ-1:0]      grant,
    output logic [1:0]           owner,
    output logic                 busy,
    output logic [3:0]           hex0,
    output logic [3:0]           hex1,
    output logic [3:0]           hex2,
    output logic [3:0]           hex3,
    output logic [3:0]           hex4,
    output logic [3:0]           hex5
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t               state_q, state_d;
    logic [NREQ-1:0]      grant_q, grant_d;
    logic [1:0]           owner_q, owner_d;
    logic [1:0]           ptr_q, ptr_d;
    logic                 busy_q, busy_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [23:0]          hex_q, hex_d;

    // Pad to the maximum of four sources so 2-bit indices never exceed the vectors.
    logic [3:0]           req_pad;
    logic [95:0]          data_pad;
    logic [1:0]           search_base;
    logic                 rr_found;
    logic [1:0]           rr_idx;
    logic [1:0]           cand;
    logic [3:0]           onehot;
    logic                 dwell_done;

    assign req_pad  = 4'(req);
    assign data_pad = 96'(data);

    function automatic logic [23:0] display_value(input logic [95:0] dv, input logic [1:0] idx);
        logic [23:0] v;
        v = dv[24*idx +: 24];
`ifdef DISP_ARB_SRCID_EN
        v[23:20] = {2'b00, idx};
`endif
        return v;
    endfunction

    // Round-robin search: from ptr+1 when idle, from owner+1 (owner excluded) at dwell expiry.
    always_comb begin
        search_base = (state_q == IDLE) ? ptr_q : owner_q;
        rr_found    = 1'b0;
        rr_idx      = 2'd0;
        cand        = 2'd0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = 2'((int'(search_base) + i) % NREQ);
            if (!rr_found && req_pad[cand] && !(state_q == HOLD && cand == owner_q)) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    assign onehot     = 4'b0001 << rr_idx;
    assign dwell_done = (cnt_q == DWELL_W'(DWELL - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (rr_found) begin
                    state_d = HOLD;
                    grant_d = onehot[NREQ-1:0];
                    owner_d = rr_idx;
                    cnt_d   = '0;
                    hex_d   = display_value(data_pad, rr_idx);
                end
            end
            HOLD: begin
                if (!req_pad[owner_q]) begin
                    // Release wins over dwell expiry; display stays frozen.
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = owner_q;
                    cnt_d   = '0;
                end else if (dwell_done) begin
                    cnt_d = '0;
                    if (rr_found) begin
                        grant_d = onehot[NREQ-1:0];
                        owner_d = rr_idx;
                        ptr_d   = owner_q;
                        hex_d   = display_value(data_pad, rr_idx);
                    end else begin
                        hex_d   = display_value(data_pad, owner_q);
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                    hex_d = display_value(data_pad, owner_q);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= 2'd0;
            ptr_q   <= 2'(NREQ - 1);
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            hex_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
        end
    end

    assign grant = grant_q;
    assign owner = owner_q;
    assign busy  = busy_q;
    assign hex0  = hex_q[3:0];
    assign hex1  = hex_q[7:4];
    assign hex2  = hex_q[11:8];
    assign hex3  = hex_q[15:12];
    assign hex4  = hex_q[19:16];
    assign hex5  = hex_q[23:20];

endmodule
